// File: rtl/pc_sequencer_if.sv
// Fetch/commit handshake bundle between the PC sequencer and its
// instruction memory / datapath environment.
interface pc_sequencer_if #(
  parameter int N     = 9,
  parameter int CNT_W = 16
);
  logic             i_run;
  logic             o_imem_req;
  logic             i_imem_ack;
  logic [N-1:0]     o_pc;
  logic             o_instr_valid;
  logic             i_stall;
  logic             i_branch_taken;
  logic [N-1:0]     i_branch_target;
  logic             i_jump;
  logic [N-1:0]     i_jump_target;
  logic             i_halt;
  logic             o_halted;
  logic [CNT_W-1:0] o_retired;

  modport master (
    input  i_run, i_imem_ack, i_stall,
    input  i_branch_taken, i_branch_target,
    input  i_jump, i_jump_target, i_halt,
    output o_imem_req, o_pc, o_instr_valid,
    output o_halted, o_retired
  );

  modport slave (
    output i_run, i_imem_ack, i_stall,
    output i_branch_taken, i_branch_target,
    output i_jump, i_jump_target, i_halt,
    input  o_imem_req, o_pc, o_instr_valid,
    input  o_halted, o_retired
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/next-PC controller: owns the word PC, fetches with req/ack,
// selects the next PC on commit, supports stall, halt/resume, retire count.
module pc_sequencer #(
  parameter int             N        = 9,
  parameter logic [N-1:0]   RESET_PC = '0,
  parameter int             CNT_W    = 16
) (
  input logic            clk,
  input logic            rst_n,
  pc_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXEC,
    HALT
  } state_t;

  localparam logic [N-1:0]     PC_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t           state;
  state_t           state_nx;
  logic [N-1:0]     pc;
  logic [N-1:0]     pc_nx;
  logic [CNT_W-1:0] retired;
  logic [CNT_W-1:0] retired_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      retired <= '0;
    end else begin
      state   <= state_nx;
      pc      <= pc_nx;
      retired <= retired_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    retired_nx = retired;
    unique case (state)
      IDLE: begin
        if (bus.i_run) state_nx = FETCH;
      end
      FETCH: begin
        if (bus.i_imem_ack) state_nx = EXEC;
      end
      EXEC: begin
        // halt beats any redirect; jump beats branch
        if (!bus.i_stall) begin
          retired_nx = retired + CNT_ONE;
          state_nx   = FETCH;
          if (bus.i_halt) begin
            pc_nx    = pc + PC_ONE;
            state_nx = HALT;
          end else if (bus.i_jump) begin
            pc_nx = bus.i_jump_target;
          end else if (bus.i_branch_taken) begin
            pc_nx = bus.i_branch_target;
          end else begin
            pc_nx = pc + PC_ONE;
          end
        end
      end
      HALT: begin
        if (bus.i_run) state_nx = FETCH;
      end
    endcase
  end

  assign bus.o_pc          = pc;
  assign bus.o_retired     = retired;
  assign bus.o_imem_req    = (state == FETCH);
  assign bus.o_instr_valid = (state == EXEC);
  assign bus.o_halted      = (state == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed commits push the expected
// PC/retire count, a negedge monitor pops and checks each commit.
module tb_pc_sequencer;

  localparam int N     = 9;
  localparam int CNT_W = 8;

  typedef struct packed {
    logic [N-1:0]     pc;
    logic [CNT_W-1:0] ret;
  } sb_t;

  typedef struct packed {
    logic         req;
    logic         valid;
    logic [N-1:0] pc;
  } tr_t;

  logic clk;
  logic rst_n;

  pc_sequencer_if #(.N(N), .CNT_W(CNT_W)) bus ();

  pc_sequencer #(
    .N(N),
    .RESET_PC('0),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_fail = 0;
  sb_t sb[$];
  tr_t trace[$];
  bit tracing = 0;
  sb_t e;
  logic [CNT_W-1:0] ret_exp = '0;
  logic [N-1:0] p;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (tracing && (bus.o_imem_req || bus.o_instr_valid))
      trace.push_back({bus.o_imem_req, bus.o_instr_valid, bus.o_pc});
    if (bus.o_instr_valid && !bus.i_stall) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL commit_unexpected: pc=%0h retired=%0h, no commit expected",
                 bus.o_pc, bus.o_retired);
      end else begin
        e = sb.pop_front();
        if (bus.o_pc !== e.pc || bus.o_retired !== e.ret) begin
          n_fail++;
          $display("FAIL commit: pc=%0h retired=%0h, expected pc=%0h retired=%0h",
                   bus.o_pc, bus.o_retired, e.pc, e.ret);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic commit(input logic [N-1:0] pc, input int stalls,
                        input logic h, input logic j,
                        input logic [N-1:0] jt, input logic b,
                        input logic [N-1:0] bt);
    int n = 0;
    while (!bus.o_instr_valid && n < 20) begin
      tick();
      n++;
    end
    if (!bus.o_instr_valid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL exec_timeout: no instr_valid, expected pc=%0h", pc);
      return;
    end
    repeat (stalls) tick();
    sb.push_back({pc, ret_exp});
    ret_exp = ret_exp + 1'b1;
    bus.i_halt = h;
    bus.i_jump = j;
    bus.i_jump_target = jt;
    bus.i_branch_taken = b;
    bus.i_branch_target = bt;
    bus.i_stall = 0;
    tick();
    bus.i_stall = 1;
    bus.i_halt = 0;
    bus.i_jump = 0;
    bus.i_branch_taken = 0;
    bus.i_jump_target = 9'h1AA;
    bus.i_branch_target = 9'h155;
  endtask

  task automatic seq(input logic [N-1:0] pc);
    commit(pc, 0, 0, 0, '0, 0, '0);
  endtask

  initial begin
    rst_n = 1;
    bus.i_run = 0;
    bus.i_imem_ack = 1;
    bus.i_stall = 1;
    bus.i_halt = 0;
    bus.i_jump = 0;
    bus.i_jump_target = '0;
    bus.i_branch_taken = 0;
    bus.i_branch_target = '0;
    #2 rst_n = 0;
    #1;
    chk("rst_pc", bus.o_pc, 0);
    chk("rst_retired", bus.o_retired, 0);
    chk("rst_req", bus.o_imem_req, 0);
    chk("rst_valid", bus.o_instr_valid, 0);
    chk("rst_halted", bus.o_halted, 0);

    // sequential fetch/exec at full rate
    bus.i_run = 1;
    tick();
    tick();
    rst_n = 1;
    tracing = 1;
    chk("idle_req", bus.o_imem_req, 0);
    for (int k = 0; k < 4; k++) seq(k[N-1:0]);
    tracing = 0;
    chk("seq_retired", bus.o_retired, 4);
    chk("seq_trace_len", trace.size(), 8);
    for (int k = 0; k < 8 && k < trace.size(); k++)
      chk("seq_trace", trace[k], {k[0] == 0, k[0] == 1, 9'(k / 2)});
    trace.delete();

    // fetch wait states then stalled exec
    bus.i_imem_ack = 0;
    tracing = 1;
    repeat (3) tick();
    bus.i_imem_ack = 1;
    commit(4, 2, 0, 0, '0, 0, '0);
    tracing = 0;
    chk("stall_trace_len", trace.size(), 7);
    for (int k = 0; k < 7 && k < trace.size(); k++)
      chk("stall_trace", trace[k], {k < 4, k >= 4, 9'd4});
    chk("stall_retired", bus.o_retired, 5);

    // redirect priority
    commit(5, 0, 0, 1, 9'h40, 1, 9'h20);
    chk("jump_pc", bus.o_pc, 9'h40);
    commit(9'h40, 0, 0, 0, 9'h0, 1, 9'h20);
    chk("branch_pc", bus.o_pc, 9'h20);

    // pc wrap
    commit(9'h20, 0, 0, 1, 9'h1FF, 0, '0);
    seq(9'h1FF);
    chk("pc_wrap", bus.o_pc, 0);
    seq(0);

    // halt with a competing jump, then resume
    bus.i_run = 0;
    commit(1, 0, 0, 1, 9'd7, 0, '0);
    commit(7, 0, 1, 1, 9'h55, 1, 9'h66);
    chk("halt_halted", bus.o_halted, 1);
    chk("halt_pc", bus.o_pc, 8);
    chk("halt_retired", bus.o_retired, 12);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("halt_req", {bus.o_imem_req, bus.o_instr_valid, bus.o_halted}, 3'b001);
    end
    bus.i_run = 1;
    tick();
    chk("resume_halted", bus.o_halted, 0);
    chk("resume_req", bus.o_imem_req, 1);
    chk("resume_pc", bus.o_pc, 8);
    seq(8);

    // retire counter wrap
    p = 9;
    while (ret_exp != 0) begin
      seq(p);
      p = p + 1'b1;
    end
    chk("cnt_wrap", bus.o_retired, 0);

    // async reset while fetching
    commit(p, 0, 0, 1, 9'h33, 0, '0);
    bus.i_imem_ack = 0;
    tick();
    tick();
    chk("pre_rst_pc", bus.o_pc, 9'h33);
    chk("pre_rst_req", bus.o_imem_req, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_pc", bus.o_pc, 0);
    chk("arst_retired", bus.o_retired, 0);
    chk("arst_flags", {bus.o_imem_req, bus.o_instr_valid, bus.o_halted}, 0);
    bus.i_run = 0;
    tick();
    rst_n = 1;
    bus.i_imem_ack = 1;
    tick();
    tick();
    bus.i_imem_ack = 0;
    chk("late_ack_flags", {bus.o_imem_req, bus.o_instr_valid, bus.o_halted}, 0);
    chk("late_ack_pc", bus.o_pc, 0);
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch/next-PC controller for the single-cycle CPU. Owns the word-addressed program counter register, requests each instruction from instruction memory with a req/ack handshake, presents it to the datapath, and selects the next PC (sequential +1, branch, jump) on commit. Supports datapath stall, a halt/resume state, and a retired-instruction counter.

## Interface

- N, 9, PC width in words; the PC increments by 1 per instruction.
- RESET_PC, 0, PC value loaded on reset.
- CNT_W, 16, width of the retired-instruction counter.

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- i_run  input  1  start/resume request, level-sensitive
- o_imem_req  output  1  fetch request to instruction memory
- i_imem_ack  input  1  instruction memory has returned the instruction for o_pc
- o_pc  output  N  current PC (registered)
- o_instr_valid  output  1  the instruction at o_pc is presented to the datapath
- i_stall  input  1  the datapath cannot commit this cycle
- i_branch_taken  input  1  conditional branch resolved taken
- i_branch_target  input  N  branch target PC
- i_jump  input  1  unconditional jump
- i_jump_target  input  N  jump target PC
- i_halt  input  1  the current instruction is a halt
- o_halted  output  1  the sequencer is in HALT
- o_retired  output  CNT_W  count of committed instructions

## Operation

- State machine: IDLE, FETCH, EXEC, HALT. State and all outputs are registered or decoded directly from the state.
- IDLE:
  - o_imem_req=0, o_instr_valid=0.
  - i_run=1 -> FETCH.
- FETCH:
  - o_imem_req=1 with o_pc held stable.
  - i_imem_ack=1 -> EXEC. Otherwise stay in FETCH indefinitely.
  - i_imem_ack is ignored in every state except FETCH.
- EXEC:
  - o_instr_valid=1.
  - A commit occurs on any EXEC cycle with i_stall=0. While i_stall=1, stay in EXEC and hold o_pc and o_retired.
  - At commit, priority is i_halt > i_jump > i_branch_taken > sequential:
    - halt: pc <= pc+1, go to HALT.
    - jump: pc <= i_jump_target, go to FETCH.
    - branch: pc <= i_branch_target, go to FETCH.
    - else: pc <= pc+1, go to FETCH.
  - Every commit, including halt, increments o_retired.
  - Control inputs are sampled only on the commit cycle and ignored otherwise.
- HALT:
  - o_halted=1, o_imem_req=0, o_instr_valid=0.
  - i_run=1 -> FETCH; execution resumes at the stored pc, i.e. the instruction after the halt.
- Arithmetic:
  - pc+1 is computed modulo 2^N, so 2^N-1 wraps to 0 with no flag.
  - Targets are taken as full N-bit values.
  - o_retired wraps modulo 2^CNT_W.
- Simultaneous events: i_jump and i_branch_taken together means the jump wins. i_halt combined with any redirect means halt wins and the redirect is discarded.

## Timing

- Reset (rst_n=0, asynchronous, immediate): state=IDLE, o_pc=RESET_PC, o_retired=0, o_imem_req=0, o_instr_valid=0, o_halted=0.
- Reset asserted mid-operation (FETCH, EXEC or HALT) aborts immediately to the reset values above. Any outstanding fetch is abandoned, and a late i_imem_ack is ignored.
- Release: the first rising edge with rst_n=1 and i_run=1 moves IDLE to FETCH. o_imem_req rises the cycle after i_run is sampled.
- i_imem_ack may arrive in the same cycle o_imem_req is high; EXEC follows on the next edge.
- Minimum throughput is 2 cycles per instruction (one FETCH cycle and one EXEC cycle), with zero-wait memory and no stall.
- The new o_pc is visible the cycle after commit, together with o_imem_req=1.
- o_pc never changes in FETCH or HALT, or in EXEC with i_stall=1.

## Test plan

- Reset/sequential: rst_n low, then high with i_run=1, ack tied high, no stall. Required: o_pc goes 0,0,1,1,2,2 on alternating FETCH/EXEC cycles. After 4 commits, o_retired=4.
- Wait states and stall: ack delayed 3 cycles, then i_stall=1 for 2 EXEC cycles. Required: o_imem_req stays high for 4 cycles with o_pc constant. o_instr_valid is high for 3 cycles. Commit occurs only on the third EXEC cycle, and o_retired increments exactly once.
- Redirect priority: at pc=5, commit with i_jump=1, i_jump_target=0x40, i_branch_taken=1, i_branch_target=0x20. Required: next o_pc=0x40. A repeat with only the branch asserted gives 0x20.
- Wrap-around: reach pc=511 (N=9) and commit sequentially. Required: next o_pc=0. Separately, preload o_retired to 0xFFFF and commit once. Required: o_retired=0.
- Halt/resume: at pc=7, commit with i_halt=1 and i_jump=1. Required: HALT entered, o_halted=1, o_pc=8, o_retired incremented, no requests issued. Then i_run=1 -> FETCH at pc=8 and o_halted=0.
- Async reset mid-fetch: drop rst_n in FETCH at pc=0x33 between clock edges. Required: outputs go to reset values immediately without waiting for a clock edge. An ack pulse arriving after release while in IDLE is ignored.
